// File: rtl/fifo_rd_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_pack_pkg
// Brief  : Shared types and helpers for the FIFO read-side byte packer.
// Rev    : 1.0 - initial release
// ============================================================================
package fifo_rd_pack_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int c_MAX_PACK = 8;

    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

    // Lane-valid mask for a word holding cnt lanes: (1 << cnt) - 1.
    function automatic logic [c_MAX_PACK-1:0] partial_keep(input int cnt);
        logic [c_MAX_PACK-1:0] mask;
        mask = '0;
        for (int i = 0; i < c_MAX_PACK; i++) begin
            if (i < cnt) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_pack_out_reg.sv
`default_nettype none
// ============================================================================
// Module : fifo_pack_out_reg
// Brief  : Single-entry valid/ready holding register for packed beats.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_pack_out_reg #(
    parameter int DATA_W = 16,
    parameter int KEEP_W = 2
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              last_o,
    output logic              valid_o,
    output logic              free_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;

    // The slot can take a new beat this cycle if it is empty or being drained.
    assign free_o = ~valid_q | ready_i;

    always_comb begin
        valid_d = load_i | (valid_q & ~ready_i);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                data_q <= data_i;
                keep_q <= keep_i;
                last_q <= last_i;
            end
        end
    end

    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_pack.sv
`default_nettype none
// ============================================================================
// Module : fifo_rd_pack
// Brief  : Pops bytes from a show-ahead FIFO and packs PACK of them per beat;
//          flush closes a partial word. FIFO_RD_PACK_STATS_EN adds counters.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_rd_pack
    import fifo_rd_pack_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int PACK  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [DSIZE-1:0]      rdata,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic                  flush,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
`ifdef FIFO_RD_PACK_STATS_EN
    ,
    output logic [31:0]           byte_cnt,
    output logic [31:0]           beat_cnt
`endif
);

    localparam int                c_CNTW = cnt_width(PACK);
    localparam logic [c_CNTW-1:0] c_FULL = c_CNTW'(PACK);

    state_t                  state_q;
    state_t                  state_d;
    logic [DSIZE*PACK-1:0]   asm_data_q;
    logic [DSIZE*PACK-1:0]   asm_data_d;
    logic [c_CNTW-1:0]       asm_cnt_q;
    logic [c_CNTW-1:0]       asm_cnt_d;
    logic [c_CNTW-1:0]       pop_lane;

    logic                    out_free;
    logic                    cnt_full;
    logic                    cnt_nz;
    logic                    xfer;
    logic                    xfer_last;
    logic [PACK-1:0]         xfer_keep;
    logic [DSIZE*PACK-1:0]   xfer_data;

    assign cnt_full  = (asm_cnt_q == c_FULL);
    assign cnt_nz    = (asm_cnt_q != '0);
    assign xfer_last = (state_q == FLUSH);
    assign xfer_keep = PACK'(partial_keep(int'(asm_cnt_q)));

    // In FLUSH any non-empty word moves out; in FILL only a complete one.
    assign xfer = out_free & ((state_q == FILL) ? cnt_full : cnt_nz);

    assign rinc = rrst_n & ~rempty & (state_q == FILL) & (~cnt_full | xfer);

    // Lanes beyond the fill level may hold stale bytes; zero them on the way out.
    for (genvar i = 0; i < PACK; i++) begin : g_lane
        assign xfer_data[i*DSIZE +: DSIZE] =
            xfer_keep[i] ? asm_data_q[i*DSIZE +: DSIZE] : '0;
    end

    always_comb begin
        asm_data_d = asm_data_q;
        asm_cnt_d  = asm_cnt_q;
        pop_lane   = xfer ? '0 : asm_cnt_q;
        if (rinc) begin
            asm_data_d[pop_lane*DSIZE +: DSIZE] = rdata;
            asm_cnt_d = pop_lane + c_CNTW'(1);
        end else if (xfer) begin
            asm_cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!cnt_nz || xfer) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= FILL;
            asm_data_q <= '0;
            asm_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            asm_data_q <= asm_data_d;
            asm_cnt_q  <= asm_cnt_d;
        end
    end

    fifo_pack_out_reg #(
        .DATA_W (DSIZE*PACK),
        .KEEP_W (PACK)
    ) u_out_reg (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .load_i  (xfer),
        .data_i  (xfer_data),
        .keep_i  (xfer_keep),
        .last_i  (xfer_last),
        .ready_i (m_ready),
        .data_o  (m_data),
        .keep_o  (m_keep),
        .last_o  (m_last),
        .valid_o (m_valid),
        .free_o  (out_free)
    );

`ifdef FIFO_RD_PACK_STATS_EN
    logic [31:0] byte_cnt_q;
    logic [31:0] beat_cnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            byte_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (rinc) begin
                byte_cnt_q <= byte_cnt_q + 32'd1;
            end
            if (m_valid && m_ready) begin
                beat_cnt_q <= beat_cnt_q + 32'd1;
            end
        end
    end

    assign byte_cnt = byte_cnt_q;
    assign beat_cnt = beat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_pack.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_rd_pack
// Brief  : Self-checking bench for fifo_rd_pack with a queue-based FIFO and
//          a byte-chunking reference model of the packed stream.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_pack;

    localparam int DSIZE = 8;
    localparam int PACK  = 2;
    localparam int W     = DSIZE * PACK;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             flush;
    logic [W-1:0]     m_data;
    logic [PACK-1:0]  m_keep;
    logic             m_last;
    logic             m_valid;
    logic             m_ready;
`ifdef FIFO_RD_PACK_STATS_EN
    logic [31:0]      byte_cnt;
    logic [31:0]      beat_cnt;
`endif

    always #5 rclk = ~rclk;

    fifo_rd_pack #(.DSIZE(DSIZE), .PACK(PACK)) dut (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .rdata   (rdata),
        .rempty  (rempty),
        .rinc    (rinc),
        .flush   (flush),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
`ifdef FIFO_RD_PACK_STATS_EN
        ,
        .byte_cnt(byte_cnt),
        .beat_cnt(beat_cnt)
`endif
    );

    typedef struct {
        logic [W-1:0]    d;
        logic [PACK-1:0] k;
        logic            l;
    } beat_t;

    beat_t            got_q[$];
    beat_t            exp_q[$];
    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] mcur[$];

    int vectors    = 0;
    int miscompares = 0;
    int pops       = 0;
    int pushed     = 0;

    logic             s_rinc;
    logic             s_valid;
    logic [W-1:0]     s_data;
    logic [PACK-1:0]  s_keep;
    logic             s_last;

    function automatic void refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? '0 : fifo_q[0];
    endfunction

    function automatic void push(input logic [DSIZE-1:0] b);
        fifo_q.push_back(b);
        pushed++;
        refresh();
    endfunction

    function automatic void add_exp(input logic [W-1:0] d, input logic [PACK-1:0] k, input logic l);
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        exp_q.push_back(b);
    endfunction

    // Reference model: popped bytes are chunked PACK at a time; a flush closes
    // whatever partial chunk remains.
    function automatic void model_emit(input logic last);
        beat_t b;
        b.d = '0; b.k = '0; b.l = last;
        for (int i = 0; i < mcur.size(); i++) begin
            b.d[i*DSIZE +: DSIZE] = mcur[i];
            b.k[i] = 1'b1;
        end
        exp_q.push_back(b);
        mcur.delete();
    endfunction

    function automatic void model_byte(input logic [DSIZE-1:0] b);
        mcur.push_back(b);
        if (mcur.size() == PACK) model_emit(1'b0);
    endfunction

    function automatic void model_flush();
        if (mcur.size() > 0) model_emit(1'b1);
    endfunction

    // One clock: sample at the falling edge, then apply the pop/accept seen there.
    task automatic cycle();
        logic acc;
        beat_t b;
        @(negedge rclk);
        s_rinc  = rinc;
        s_valid = m_valid;
        s_data  = m_data;
        s_keep  = m_keep;
        s_last  = m_last;
        acc     = m_valid & m_ready;
        @(posedge rclk);
        #1;
        if (s_rinc && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (acc) begin
            b.d = s_data; b.k = s_keep; b.l = s_last;
            got_q.push_back(b);
        end
        refresh();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apply_reset();
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        fifo_q.delete();
        refresh();
        cycles(2);
        rrst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        mcur.delete();
        pops   = 0;
        pushed = 0;
    endtask

    task automatic test_reset();
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        fifo_q.delete();
        push(8'h99);
        cycle();
        vectors++; if (s_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", s_valid); end
        vectors++; if (s_data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", s_data); end
        vectors++; if (s_keep !== '0) begin miscompares++; $display("FAIL reset_keep got %b want 0", s_keep); end
        vectors++; if (s_last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b want 0", s_last); end
        vectors++; if (s_rinc !== 1'b0) begin miscompares++; $display("FAIL reset_rinc got %b want 0", s_rinc); end
    endtask

    task automatic test_stream();
        apply_reset();
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++; if (s_rinc !== 1'b1) begin miscompares++; $display("FAIL stream_rinc cycle %0d got %b want 1", i, s_rinc); end
        end
        cycles(4);
        add_exp(16'h2211, 2'b11, 1'b0);
        add_exp(16'h4433, 2'b11, 1'b0);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL stream_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL stream_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DSIZE'(8'h11 * i));
        cycles(10);
        vectors++; if (pops != 2*PACK) begin miscompares++; $display("FAIL bp_pops got %0d want %0d", pops, 2*PACK); end
        vectors++; if (s_rinc !== 1'b0) begin miscompares++; $display("FAIL bp_rinc_stalled got %b want 0", s_rinc); end
        m_ready = 1'b1;
        cycles(12);
        add_exp(16'h2211, 2'b11, 1'b0);
        add_exp(16'h4433, 2'b11, 1'b0);
        add_exp(16'h6655, 2'b11, 1'b0);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL bp_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
    endtask

    task automatic test_partial_flush();
        apply_reset();
        m_ready = 1'b1;
        push(8'hA1); push(8'hB2); push(8'hC3);
        cycles(5);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        push(8'hD4);
        cycle();
        vectors++; if (s_rinc !== 1'b0) begin miscompares++; $display("FAIL pflush_no_pop got %b want 0", s_rinc); end
        push(8'hE5);
        cycles(6);
        add_exp(16'hB2A1, 2'b11, 1'b0);
        add_exp(16'h00C3, 2'b01, 1'b1);
        add_exp(16'hE5D4, 2'b11, 1'b0);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL pflush_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL pflush_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
`ifdef FIFO_RD_PACK_STATS_EN
        vectors++; if (byte_cnt !== 32'd5) begin miscompares++; $display("FAIL stats_bytes got %0d want 5", byte_cnt); end
        vectors++; if (beat_cnt !== 32'd3) begin miscompares++; $display("FAIL stats_beats got %0d want 3", beat_cnt); end
`endif
    endtask

    task automatic test_empty_flush();
        apply_reset();
        m_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        push(8'h5A);
        cycle();
        vectors++; if (s_rinc !== 1'b0) begin miscompares++; $display("FAIL eflush_flush_rinc got %b want 0", s_rinc); end
        cycle();
        vectors++; if (s_rinc !== 1'b1) begin miscompares++; $display("FAIL eflush_resume_rinc got %b want 1", s_rinc); end
        push(8'h6B);
        cycles(6);
        add_exp(16'h6B5A, 2'b11, 1'b0);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL eflush_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL eflush_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
    endtask

    task automatic test_full_boundary();
        apply_reset();
        m_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        cycles(6);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycles(2);
        m_ready = 1'b1;
        cycles(4);
        add_exp(16'h2211, 2'b11, 1'b0);
        add_exp(16'h4433, 2'b11, 1'b1);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL fboundary_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL fboundary_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
        cycles(4);
        vectors++; if (s_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_valid got %b want 1", s_valid); end
        push(8'h44);
        rrst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (s_valid !== 1'b0 || s_keep !== '0 || s_last !== 1'b0 || s_data !== '0 || s_rinc !== 1'b0) begin
                miscompares++;
                $display("FAIL rmid_in_reset got v%b k%b l%b d%h rinc%b want all 0", s_valid, s_keep, s_last, s_data, s_rinc);
            end
        end
        rrst_n = 1'b1;
        got_q.delete();
        push(8'h55);
        m_ready = 1'b1;
        cycles(6);
        add_exp(16'h5544, 2'b11, 1'b0);
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL rmid_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
    endtask

    task automatic test_random();
        logic [DSIZE-1:0] b;
        int guard;
        apply_reset();
        for (int seg = 0; seg < 8; seg++) begin
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(1, 0) == 1) begin
                    b = DSIZE'($urandom);
                    push(b);
                    model_byte(b);
                end
                m_ready = ($urandom_range(3, 0) != 0);
                cycle();
            end
            m_ready = 1'b1;
            guard = 0;
            while (fifo_q.size() > 0 && guard < 300) begin
                cycle();
                guard++;
            end
            vectors++; if (fifo_q.size() != 0) begin miscompares++; $display("FAIL rand_drain_timeout seg %0d left %0d want 0", seg, fifo_q.size()); end
            cycles(2*PACK + 6);
            if ($urandom_range(1, 0) == 1 || seg == 7) begin
                model_flush();
                flush = 1'b1;
                cycle();
                flush = 1'b0;
                cycles(4);
            end
        end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i].d !== exp_q[i].d || got_q[i].k !== exp_q[i].k || got_q[i].l !== exp_q[i].l) begin
                miscompares++;
                $display("FAIL rand_beat%0d got %h/%b/%b want %h/%b/%b", i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
`ifdef FIFO_RD_PACK_STATS_EN
        vectors++; if (byte_cnt !== 32'(pushed)) begin miscompares++; $display("FAIL rand_stats_bytes got %0d want %0d", byte_cnt, pushed); end
        vectors++; if (beat_cnt !== 32'(exp_q.size())) begin miscompares++; $display("FAIL rand_stats_beats got %0d want %0d", beat_cnt, exp_q.size()); end
`endif
    endtask

    initial begin
        rrst_n  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        refresh();
        test_reset();
        test_stream();
        test_backpressure();
        test_partial_flush();
        test_empty_flush();
        test_full_boundary();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
